// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single byte-wide, read-only simple_memory port between N_REQ burst requesters
//   (requester 0 = instruction fetch, requester 1 = load_m tile loader). One whole burst is
//   granted at a time, round-robin between requesters, and bytes are streamed back over the
//   memory's 1-cycle synchronous read latency.
//
// Ports
//   clk       clock, all state on posedge
//   rst       asynchronous, active-high reset
//   req       level request per requester
//   req_addr  per-requester burst base byte address, sampled at grant
//   req_len   per-requester burst length in bytes, sampled at grant
//   gnt       one-hot 1-cycle pulse: burst accepted
//   busy      high from the grant cycle through the done cycle
//   owner     index of the current/last granted requester
//   mem_addr  byte address to simple_memory
//   mem_dout  data from simple_memory, valid one cycle after mem_addr
//   rd_data   returned byte (shared bus, = mem_dout)
//   rd_valid  one-hot: rd_data belongs to that requester this cycle
//   rd_last   final byte of the burst
//   done      one-hot 1-cycle pulse on burst completion
module mem_port_arbiter #(
  parameter int unsigned N_REQ      = 2,
  parameter int unsigned ADDR_WIDTH = 24,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 20
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [N_REQ-1:0]                     req,
  input  logic [N_REQ-1:0][ADDR_WIDTH-1:0]     req_addr,
  input  logic [N_REQ-1:0][LEN_WIDTH-1:0]      req_len,
  output logic [N_REQ-1:0]                     gnt,
  output logic                                 busy,
  output logic [$clog2(N_REQ)-1:0]             owner,
  output logic [ADDR_WIDTH-1:0]                mem_addr,
  input  logic [DATA_WIDTH-1:0]                mem_dout,
  output logic [DATA_WIDTH-1:0]                rd_data,
  output logic [N_REQ-1:0]                     rd_valid,
  output logic                                 rd_last,
  output logic [N_REQ-1:0]                     done
);

  localparam int unsigned IdxW = $clog2(N_REQ);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StBurst = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [N_REQ-1:0]      gnt_q, gnt_d;
  logic [IdxW-1:0]       owner_q, owner_d;
  logic [IdxW-1:0]       rr_q, rr_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
  logic [N_REQ-1:0]      rd_valid_q, rd_valid_d;
  logic                  rd_last_q, rd_last_d;
  logic [N_REQ-1:0]      done_q, done_d;

  // Round-robin pick: first asserted req strictly after the last-granted index.
  logic            win_valid;
  logic [IdxW-1:0] win_idx;
  int unsigned     cand;

  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      cand = int'(rr_q) + i;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!win_valid && req[cand]) begin
        win_valid = 1'b1;
        win_idx   = IdxW'(cand);
      end
    end
  end

  logic [N_REQ-1:0]     owner_oh;
  logic                 last_byte;
  logic [LEN_WIDTH-1:0] cnt_inc;

  assign owner_oh  = N_REQ'(1) << owner_q;
  assign last_byte = (cnt_q == len_q - LEN_WIDTH'(1));
  assign cnt_inc   = cnt_q + LEN_WIDTH'(1);

  always_comb begin
    state_d    = state_q;
    gnt_d      = '0;
    owner_d    = owner_q;
    rr_d       = rr_q;
    mem_addr_d = mem_addr_q;
    base_d     = base_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    rd_valid_d = '0;
    rd_last_d  = 1'b0;
    done_d     = '0;

    case (state_q)
      StBurst: begin
        if (len_q == '0) begin
          // Zero-length burst: nothing is read, just complete.
          done_d  = owner_oh;
          state_d = StDrain;
        end else begin
          // Byte cnt_q is on mem_addr now; its data returns next cycle.
          rd_valid_d = owner_oh;
          if (last_byte) begin
            rd_last_d = 1'b1;
            done_d    = owner_oh;
            state_d   = StDrain;
          end else begin
            cnt_d      = cnt_inc;
            mem_addr_d = base_q + ADDR_WIDTH'(cnt_inc);
          end
        end
      end
      StIdle, StDrain: begin
        if (win_valid) begin
          gnt_d      = N_REQ'(1) << win_idx;
          owner_d    = win_idx;
          rr_d       = win_idx;
          mem_addr_d = req_addr[win_idx];
          base_d     = req_addr[win_idx];
          len_d      = req_len[win_idx];
          cnt_d      = '0;
          state_d    = StBurst;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      gnt_q      <= '0;
      owner_q    <= '0;
      rr_q       <= IdxW'(N_REQ - 1);  // so requester 0 wins the first tie
      mem_addr_q <= '0;
      base_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      rd_valid_q <= '0;
      rd_last_q  <= 1'b0;
      done_q     <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      owner_q    <= owner_d;
      rr_q       <= rr_d;
      mem_addr_q <= mem_addr_d;
      base_q     <= base_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      done_q     <= done_d;
    end
  end

  assign gnt      = gnt_q;
  assign busy     = (state_q != StIdle);
  assign owner    = owner_q;
  assign mem_addr = mem_addr_q;
  assign rd_data  = mem_dout;
  assign rd_valid = rd_valid_q;
  assign rd_last  = rd_last_q;
  assign done     = done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter with a 1-cycle-latency memory model.
module tb_mem_port_arbiter;

  logic              clk;
  logic              rst;
  logic [1:0]        req;
  logic [1:0][23:0]  req_addr;
  logic [1:0][19:0]  req_len;
  logic [1:0]        gnt;
  logic              busy;
  logic [0:0]        owner;
  logic [23:0]       mem_addr;
  logic [7:0]        mem_dout;
  logic [7:0]        rd_data;
  logic [1:0]        rd_valid;
  logic              rd_last;
  logic [1:0]        done;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  mem_port_arbiter #(
    .N_REQ(2), .ADDR_WIDTH(24), .DATA_WIDTH(8), .LEN_WIDTH(20)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_addr (req_addr),
    .req_len  (req_len),
    .gnt      (gnt),
    .busy     (busy),
    .owner    (owner),
    .mem_addr (mem_addr),
    .mem_dout (mem_dout),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_last  (rd_last),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input logic [23:0] a);
    case (a)
      24'h000100: return 8'h11;
      24'h000101: return 8'h22;
      24'h000102: return 8'h33;
      24'h000103: return 8'h44;
      default:    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h5A;
    endcase
  endfunction

  // simple_memory: synchronous read, one cycle latency
  always_ff @(posedge clk) mem_dout <= mem_byte(mem_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_gnt"},      32'(gnt),      32'h0);
    check({tag, "_busy"},     32'(busy),     32'h0);
    check({tag, "_owner"},    32'(owner),    32'h0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'h0);
    check({tag, "_rd_valid"}, 32'(rd_valid), 32'h0);
    check({tag, "_rd_last"},  32'(rd_last),  32'h0);
    check({tag, "_done"},     32'(done),     32'h0);
  endtask

  // Wait (bounded) for gnt[idx]; returns 1 when seen.
  task automatic wait_gnt(input int idx, input int budget, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < budget && !ok; t++) begin
      step();
      if (gnt[idx]) ok = 1'b1;
    end
    check("gnt_seen", 32'(ok), 32'h1);
  endtask

  // Request one burst and check every cycle from grant to busy dropping.
  task automatic run_burst(input int idx, input logic [23:0] addr, input int len, input string tag);
    bit          ok;
    logic [1:0]  oh;
    logic [23:0] ea;
    oh = 2'(1 << idx);
    req_addr[idx] = addr;
    req_len[idx]  = 20'(len);
    req[idx]      = 1'b1;
    wait_gnt(idx, 20, ok);
    req[idx] = 1'b0;
    if (!ok) return;
    check({tag, "_gnt"},   32'(gnt),      32'(oh));
    check({tag, "_busy"},  32'(busy),     32'h1);
    check({tag, "_owner"}, 32'(owner),    32'(idx));
    check({tag, "_addr0"}, 32'(mem_addr), 32'(addr));
    if (len == 0) begin
      step();
      check({tag, "_done"},     32'(done),     32'(oh));
      check({tag, "_rd_valid"}, 32'(rd_valid), 32'h0);
      check({tag, "_rd_last"},  32'(rd_last),  32'h0);
      check({tag, "_busy1"},    32'(busy),     32'h1);
    end else begin
      for (int k = 0; k < len; k++) begin
        step();
        ea = (k < len - 1) ? addr + 24'(k + 1) : addr + 24'(len - 1);
        check({tag, "_rd_valid"}, 32'(rd_valid), 32'(oh));
        check({tag, "_rd_data"},  32'(rd_data),  32'(mem_byte(addr + 24'(k))));
        check({tag, "_rd_last"},  32'(rd_last),  (k == len - 1) ? 32'h1 : 32'h0);
        check({tag, "_done"},     32'(done),     (k == len - 1) ? 32'(oh) : 32'h0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'(ea));
        check({tag, "_busy"},     32'(busy),     32'h1);
      end
    end
    step();
    check({tag, "_busy_end"},  32'(busy),     32'h0);
    check({tag, "_valid_end"}, 32'(rd_valid), 32'h0);
    check({tag, "_done_end"},  32'(done),     32'h0);
  endtask

  initial begin
    bit ok;
    int last_g;
    rst      = 1'b1;
    req      = '0;
    req_addr = '0;
    req_len  = '0;
    step();
    check_reset_vals("reset");
    step();
    rst = 1'b0;

    // Tie out of reset: requester 0 first, then strict alternation, 3 cycles apart.
    req_addr[0] = 24'h000500; req_len[0] = 20'd2;
    req_addr[1] = 24'h000600; req_len[1] = 20'd2;
    req = 2'b11;
    last_g = 0;
    for (int r = 0; r < 6; r++) begin
      ok = 1'b0;
      for (int t = 0; t < 10 && !ok; t++) begin
        step();
        if (gnt != 2'b00) ok = 1'b1;
      end
      check("rr_gnt_seen", 32'(ok), 32'h1);
      check("rr_gnt", 32'(gnt), (r % 2 == 0) ? 32'h1 : 32'h2);
      if (r > 0) check("rr_spacing", 32'(cyc - last_g), 32'd3);
      last_g = cyc;
      if (r == 5) req = 2'b00;
    end
    ok = 1'b0;
    for (int t = 0; t < 10 && !ok; t++) begin
      step();
      if (!busy) ok = 1'b1;
    end
    check("rr_idle", 32'(ok), 32'h1);

    // Single burst, zero length, address wrap.
    run_burst(1, 24'h000100, 4, "single");
    run_burst(0, 24'h000700, 0, "zero");
    run_burst(0, 24'hFFFFFE, 4, "wrap");

    // Mid-burst request from 1 and early drop by 0.
    req_addr[0] = 24'h000200; req_len[0] = 20'd8; req[0] = 1'b1;
    wait_gnt(0, 20, ok);
    if (ok) begin
      for (int k = 0; k < 8; k++) begin
        step();
        if (k == 0) begin
          req[0] = 1'b0;
          req_addr[1] = 24'h000300; req_len[1] = 20'd2; req[1] = 1'b1;
        end
        check("mid_rd_valid", 32'(rd_valid), 32'h1);
        check("mid_rd_data",  32'(rd_data),  32'(mem_byte(24'h000200 + 24'(k))));
        check("mid_no_gnt",   32'(gnt),      32'h0);
        check("mid_done",     32'(done),     (k == 7) ? 32'h1 : 32'h0);
      end
      step();
      check("mid_gnt1", 32'(gnt), 32'h2);
      req[1] = 1'b0;
      step();
      step();
      check("mid_done1", 32'(done), 32'h2);
      check("mid_data1", 32'(rd_data), 32'(mem_byte(24'h000301)));
      step();
      check("mid_idle", 32'(busy), 32'h0);
    end
    req = 2'b00;

    // Reset during byte 3 of an 8-byte burst.
    req_addr[0] = 24'h000400; req_len[0] = 20'd8; req[0] = 1'b1;
    wait_gnt(0, 20, ok);
    req[0] = 1'b0;
    for (int k = 0; k < 4; k++) step();
    check("pre_rst_data", 32'(rd_data), 32'(mem_byte(24'h000403)));
    #2 rst = 1'b1;
    #1 check_reset_vals("async_rst");
    for (int k = 0; k < 2; k++) begin
      step();
      check("rst_no_done", 32'(done), 32'h0);
      check("rst_busy",    32'(busy), 32'h0);
    end
    rst = 1'b0;
    step();
    check("post_rst_done", 32'(done), 32'h0);
    run_burst(0, 24'h000400, 8, "rerun");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
